// File: rtl/ram_bank_ctrl.sv
// Two-port round-robin controller for a bank of 1-bit asynchronous SRAM chips.
// Each access runs IDLE -> SETUP -> PULSE (PulseCycles) -> HOLD with registered strobes.
module ram_bank_ctrl #(
    parameter int AddressSize = 12,
    parameter int WordWidth   = 64,
    parameter int PulseCycles = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0,
    input  logic                   req1,
    input  logic                   we0,
    input  logic                   we1,
    input  logic [AddressSize-1:0] addr0,
    input  logic [AddressSize-1:0] addr1,
    input  logic [WordWidth-1:0]   wdata0,
    input  logic [WordWidth-1:0]   wdata1,
    output logic                   ack0,
    output logic                   ack1,
    output logic [WordWidth-1:0]   rd_data,
    output logic                   busy,
    output logic [AddressSize-1:0] ram_addr,
    output logic [WordWidth-1:0]   ram_din,
    input  logic [WordWidth-1:0]   ram_dout,
    output logic                   ram_cs_n,
    output logic                   ram_we_n,
    output logic                   ram_oe_n
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam logic [3:0] PulseLoad = 4'(PulseCycles);

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   last_grant_q, last_grant_d;
    logic                   grant_q, grant_d;
    logic                   op_we_q, op_we_d;
    logic [AddressSize-1:0] ram_addr_q, ram_addr_d;
    logic [WordWidth-1:0]   ram_din_q, ram_din_d;
    logic [WordWidth-1:0]   rd_data_q, rd_data_d;
    logic                   cs_n_q, cs_n_d;
    logic                   we_n_q, we_n_d;
    logic                   oe_n_q, oe_n_d;
    logic                   ack0_q, ack0_d;
    logic                   ack1_q, ack1_d;
    logic                   busy_q, busy_d;
    logic                   pick_s;

    // Next-state sequencing, arbitration and the strobe values for the state being entered
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        op_we_d      = op_we_q;
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        rd_data_d    = rd_data_q;
        pick_s       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // last_grant_q = 1 means port 1 went last, so port 0 wins a tie
                if (req0 && req1) begin
                    pick_s = ~last_grant_q;
                end else begin
                    pick_s = req1;
                end
                if (req0 || req1) begin
                    state_d      = ST_SETUP;
                    grant_d      = pick_s;
                    last_grant_d = pick_s;
                    op_we_d      = pick_s ? we1 : we0;
                    ram_addr_d   = pick_s ? addr1 : addr0;
                    ram_din_d    = pick_s ? wdata1 : wdata0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d = ST_PULSE;
                cnt_d   = PulseLoad;
            end
            ST_PULSE: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_HOLD;
                    if (!op_we_q) begin
                        rd_data_d = ram_dout;
                    end else begin
                        rd_data_d = rd_data_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cs_n_d = (state_d != ST_PULSE);
        we_n_d = !((state_d == ST_PULSE) && op_we_d);
        oe_n_d = !((state_d == ST_PULSE) && !op_we_d);
        ack0_d = (state_d == ST_HOLD) && !grant_d;
        ack1_d = (state_d == ST_HOLD) && grant_d;
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            op_we_q      <= 1'b0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            rd_data_q    <= '0;
            cs_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            oe_n_q       <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            op_we_q      <= op_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            rd_data_q    <= rd_data_d;
            cs_n_q       <= cs_n_d;
            we_n_q       <= we_n_d;
            oe_n_q       <= oe_n_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            busy_q       <= busy_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rd_data  = rd_data_q;
    assign busy     = busy_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign ram_cs_n = cs_n_q;
    assign ram_we_n = we_n_q;
    assign ram_oe_n = oe_n_q;

endmodule

// File: tb/tb_ram_bank_ctrl.sv
// Bench for ram_bank_ctrl: three instances (P=2 directed+random, P=1 and P=5 random),
// each with a behavioural chip array, a per-cycle invariant monitor and a transaction-level model.
module tb_ram_bank_ctrl;

    typedef struct packed {
        logic        port;
        logic        we;
        logic [11:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rd;
    } vec_t;

    logic       clk = 1'b0;
    int         errors = 0;
    int         checks = 0;
    logic [2:0] done_v = 3'b000;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int P = (gi == 0) ? 2 : ((gi == 1) ? 1 : 5);

        logic        rst_n, req0, req1, we0, we1;
        logic [11:0] addr0, addr1, ram_addr;
        logic [63:0] wdata0, wdata1, ram_din, ram_dout, rd_data;
        logic        ack0, ack1, busy, cs_n, we_n, oe_n;
        logic [63:0] chip [4096];
        logic [63:0] ref_mem [int];

        ram_bank_ctrl #(.AddressSize(12), .WordWidth(64), .PulseCycles(P)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req0(req0), .req1(req1), .we0(we0), .we1(we1),
            .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
            .ack0(ack0), .ack1(ack1), .rd_data(rd_data), .busy(busy),
            .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
            .ram_cs_n(cs_n), .ram_we_n(we_n), .ram_oe_n(oe_n)
        );

        // chip array: write while CS and WE are low, drive outputs while CS and OE are low
        always @(posedge clk) begin
            if (cs_n === 1'b0 && we_n === 1'b0) chip[ram_addr] <= ram_din;
        end
        assign ram_dout = (cs_n === 1'b0 && oe_n === 1'b0) ? chip[ram_addr] : 64'h0;

        task automatic ck(input string nm, input logic [63:0] act, input logic [63:0] exp);
            chk($sformatf("P%0d_%s", P, nm), act, exp);
        endtask

        logic        prv_rst, prv_busy;
        logic [11:0] prv_addr;
        logic [63:0] prv_din;
        always @(negedge clk) begin
            #1;
            if (prv_rst === 1'b1) begin
                ck("inv_we_oe", 64'(!we_n && !oe_n), 64'd0);
                ck("inv_strobe_cs", 64'((!we_n || !oe_n) && cs_n), 64'd0);
                ck("inv_two_acks", 64'(ack0 && ack1), 64'd0);
                ck("inv_addr_din_stable",
                   64'(((ram_addr !== prv_addr) || (ram_din !== prv_din)) && !(!prv_busy && busy)), 64'd0);
            end
            prv_rst  = rst_n;
            prv_busy = busy;
            prv_addr = ram_addr;
            prv_din  = ram_din;
        end

        task automatic init_inputs();
            rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
            addr0 = 12'h0; addr1 = 12'h0; wdata0 = 64'h0; wdata1 = 64'h0;
        endtask

        // Transaction-level model: one access at a time, granted in an idle cycle,
        // strobes/ack/busy timed from the grant cycle, round robin on ties.
        task automatic run_random(input int n_tx);
            int          cyc, free_at, g, n_gr;
            bit          gv, g_port, g_we, g_chk, last_port, w;
            bit          in_pulse, exp_busy, exp_ack;
            logic [11:0] g_addr;
            logic [63:0] g_din, g_exp;
            bit          pend [2], infl [2], drop [2], rwe [2];
            logic [11:0] raddr [2];
            logic [63:0] rdat [2];
            ref_mem.delete();
            init_inputs();
            @(negedge clk); @(negedge clk);
            rst_n = 1'b1;
            cyc = 0; free_at = 0; g = 0; n_gr = 0; gv = 1'b0; last_port = 1'b1;
            g_port = 1'b0; g_we = 1'b0; g_chk = 1'b0; g_addr = 12'h0; g_din = 64'h0; g_exp = 64'h0;
            for (int p = 0; p < 2; p++) begin
                pend[p] = 1'b0; infl[p] = 1'b0; drop[p] = 1'b0; rwe[p] = 1'b0;
                raddr[p] = 12'h0; rdat[p] = 64'h0;
            end
            while ((n_gr < n_tx || cyc < free_at || pend[0] || pend[1]) && cyc < 40000) begin
                in_pulse = gv && (cyc >= g + 2) && (cyc <= g + 1 + P);
                exp_busy = gv && (cyc >= g + 1) && (cyc <= g + 2 + P);
                exp_ack  = gv && (cyc == g + 2 + P);
                ck("busy", 64'(busy), 64'(exp_busy));
                ck("cs_n", 64'(cs_n), 64'(!in_pulse));
                ck("we_n", 64'(we_n), 64'(!(in_pulse && g_we)));
                ck("oe_n", 64'(oe_n), 64'(!(in_pulse && !g_we)));
                ck("ack0", 64'(ack0), 64'(exp_ack && !g_port));
                ck("ack1", 64'(ack1), 64'(exp_ack && g_port));
                if (exp_busy) begin
                    ck("ram_addr", 64'(ram_addr), 64'(g_addr));
                    if (g_we) ck("ram_din", ram_din, g_din);
                end
                if (exp_ack && !g_we && g_chk) ck("rnd_rd_data", rd_data, g_exp);

                for (int p = 0; p < 2; p++) begin
                    if (exp_ack && (int'(g_port) == p)) begin
                        infl[p] = 1'b0;
                        drop[p] = 1'b0;
                    end else if (infl[p] && !drop[p] && $urandom_range(0, 3) == 0) begin
                        drop[p] = 1'b1;
                    end
                    if (!pend[p] && !infl[p] && n_gr < n_tx && $urandom_range(0, 2) != 0) begin
                        pend[p]  = 1'b1;
                        rwe[p]   = 1'($urandom_range(0, 1));
                        raddr[p] = ($urandom_range(0, 9) == 0) ? 12'hFFF : 12'($urandom_range(0, 7));
                        rdat[p]  = {$urandom, $urandom};
                    end
                end
                req0 = pend[0] || (infl[0] && !drop[0]);
                req1 = pend[1] || (infl[1] && !drop[1]);
                we0 = rwe[0]; addr0 = raddr[0]; wdata0 = rdat[0];
                we1 = rwe[1]; addr1 = raddr[1]; wdata1 = rdat[1];

                if (cyc >= free_at && (pend[0] || pend[1])) begin
                    if (pend[0] && pend[1]) w = !last_port;
                    else                    w = pend[1];
                    last_port = w;
                    gv = 1'b1; g = cyc; free_at = cyc + 3 + P; n_gr++;
                    g_port = w; g_we = rwe[w]; g_addr = raddr[w]; g_din = rdat[w];
                    g_chk = ref_mem.exists(int'(g_addr));
                    g_exp = g_chk ? ref_mem[int'(g_addr)] : 64'h0;
                    if (g_we) ref_mem[int'(g_addr)] = g_din;
                    pend[w] = 1'b0;
                    infl[w] = 1'b1;
                end
                @(negedge clk);
                cyc++;
            end
            req0 = 1'b0; req1 = 1'b0;
            ck("rnd_completed", 64'(cyc < 40000), 64'd1);
        endtask

        if (gi == 0) begin : g_dir
            vec_t vecs [8];

            task automatic do_tx(input vec_t v, input int idx);
                int    k, cs_c, we_c, oe_c;
                bit    got;
                string nm;
                nm = $sformatf("vec%0d", idx);
                if (v.port) begin
                    req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
                end else begin
                    req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
                end
                k = 0; cs_c = 0; we_c = 0; oe_c = 0; got = 1'b0;
                while (!got && k < 20) begin
                    @(negedge clk);
                    k++;
                    if (k == 1) ck({nm, "_setup"}, 64'({busy, cs_n, we_n, oe_n}), 64'hF);
                    if (cs_n == 1'b0) cs_c++;
                    if (we_n == 1'b0) we_c++;
                    if (oe_n == 1'b0) oe_c++;
                    got = ack0 | ack1;
                end
                req0 = 1'b0; req1 = 1'b0;
                ck({nm, "_ack_latency"}, 64'(k), 64'(P + 2));
                ck({nm, "_ack_port"}, 64'({ack1, ack0}), v.port ? 64'd2 : 64'd1);
                ck({nm, "_cs_cycles"}, 64'(cs_c), 64'(P));
                ck({nm, "_we_cycles"}, 64'(we_c), v.we ? 64'(P) : 64'd0);
                ck({nm, "_oe_cycles"}, 64'(oe_c), v.we ? 64'd0 : 64'(P));
                if (v.we) ck({nm, "_chip"}, chip[v.addr], v.wdata);
                else      ck({nm, "_rd_data"}, rd_data, v.exp_rd);
                @(negedge clk);
            endtask

            initial begin : directed
                int          n_ack, k;
                int          ack_k [4];
                int          ack_p [4];
                bit          any;
                vecs[0] = '{1'b0, 1'b1, 12'h123, 64'hDEADBEEF_00000001, 64'h0};
                vecs[1] = '{1'b1, 1'b0, 12'h123, 64'h0, 64'hDEADBEEF_00000001};
                vecs[2] = '{1'b1, 1'b1, 12'h000, 64'h01234567_89ABCDEF, 64'h0};
                vecs[3] = '{1'b0, 1'b1, 12'hFFF, 64'hA5A5A5A5_5A5A5A5A, 64'h0};
                vecs[4] = '{1'b1, 1'b0, 12'h000, 64'h0, 64'h01234567_89ABCDEF};
                vecs[5] = '{1'b0, 1'b0, 12'hFFF, 64'h0, 64'hA5A5A5A5_5A5A5A5A};
                vecs[6] = '{1'b1, 1'b0, 12'h123, 64'h0, 64'hDEADBEEF_00000001};
                vecs[7] = '{1'b1, 1'b0, 12'h123, 64'h0, 64'hDEADBEEF_00000001};

                init_inputs();
                @(negedge clk); @(negedge clk);
                ck("rst_strobes", 64'({cs_n, we_n, oe_n}), 64'h7);
                ck("rst_acks_busy", 64'({ack0, ack1, busy}), 64'h0);
                ck("rst_ram_addr", 64'(ram_addr), 64'h0);
                ck("rst_ram_din", ram_din, 64'h0);
                ck("rst_rd_data", rd_data, 64'h0);
                rst_n = 1'b1;
                @(negedge clk);
                for (int i = 0; i < 7; i++) do_tx(vecs[i], i);

                // both ports held high: grants must alternate starting with port 0
                req0 = 1'b1; we0 = 1'b0; addr0 = 12'h123;
                req1 = 1'b1; we1 = 1'b0; addr1 = 12'hFFF;
                n_ack = 0; k = 0;
                for (int i = 0; i < 4; i++) begin ack_k[i] = -100; ack_p[i] = 9; end
                while (n_ack < 4 && k < 40) begin
                    @(negedge clk);
                    k++;
                    if (ack0 || ack1) begin
                        ack_k[n_ack] = k;
                        ack_p[n_ack] = int'(ack1);
                        ck("rr_rd_data", rd_data, ack1 ? 64'hA5A5A5A5_5A5A5A5A : 64'hDEADBEEF_00000001);
                        n_ack++;
                    end
                end
                req0 = 1'b0; req1 = 1'b0;
                @(negedge clk);
                ck("rr_ack_count", 64'(n_ack), 64'd4);
                ck("rr_first_latency", 64'(ack_k[0]), 64'(P + 2));
                for (int i = 0; i < 4; i++) ck($sformatf("rr_grant%0d", i), 64'(ack_p[i]), 64'(i % 2));
                for (int i = 1; i < 4; i++) ck($sformatf("rr_spacing%0d", i), 64'(ack_k[i] - ack_k[i - 1]), 64'(P + 3));

                // reset during the write pulse abandons the access
                req0 = 1'b1; we0 = 1'b1; addr0 = 12'h0AA; wdata0 = 64'h55555555_AAAAAAAA;
                @(negedge clk);
                @(negedge clk);
                ck("mid_in_pulse", 64'({cs_n, we_n}), 64'h0);
                rst_n = 1'b0; req0 = 1'b0;
                @(negedge clk);
                ck("mid_rst_strobes", 64'({cs_n, we_n, oe_n}), 64'h7);
                ck("mid_rst_acks_busy", 64'({ack0, ack1, busy}), 64'h0);
                ck("mid_rst_ram_addr", 64'(ram_addr), 64'h0);
                ck("mid_rst_rd_data", rd_data, 64'h0);
                rst_n = 1'b1;
                any = 1'b0;
                repeat (6) begin
                    @(negedge clk);
                    any = any | ack0 | ack1 | busy;
                end
                ck("mid_rst_no_ack", 64'(any), 64'h0);
                do_tx(vecs[7], 7);

                run_random(300);
                done_v[gi] = 1'b1;
            end
        end else begin : g_rnd
            initial begin
                run_random(1000);
                done_v[gi] = 1'b1;
            end
        end
    end

    initial begin : summary
        for (int c = 0; c < 60000 && done_v != 3'b111; c++) @(negedge clk);
        chk("all_instances_done", 64'(done_v), 64'h7);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
